udl_mod_counter: RTL and testbench
==================================

Name: udl_mod_counter

Overview:
Parametrised up/down/load counter with a programmable modulus (limit), programmable step size, wrap-or-saturate boundary mode and terminal-count signalling. It succeeds the fixed-range up/down/load counter. It serves as a general timer, divider and event counter in datapath and control logic. Count range is [0, limit]. Synchronous design on a single clock.

Parameters:
bits, 8, counter/limit/load width
step_bits, 4, width of the step input (step_bits <= bits)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  count enable (one step per cycle when high)
up  input  1  1 = count up, 0 = count down
load  input  1  synchronous load of D
D  input  bits  load data
step  input  step_bits  increment/decrement amount
limit  input  bits  upper bound of count range (inclusive)
sat_mode  input  1  1 = saturate at bounds, 0 = wrap
clear  input  1  synchronous clear of Q and ovf
Q  output  bits  registered count
tc  output  1  registered terminal-count pulse
ovf  output  1  registered sticky boundary-event flag
at_max  output  1  combinational, Q == limit
at_zero  output  1  combinational, Q == 0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). No asynchronous paths.
- Reset values: Q=0, tc=0, ovf=0. at_max and at_zero follow from Q=0 and the current limit.
- Update priority, evaluated per rising edge: reset > clear > load > (enable count) > hold.
- clear: Q=0, ovf=0, tc=0.
- load: Q = D if D <= limit, else Q = limit (clamped). tc=0. ovf unchanged. Load ignores enable and up.
- enable=0 with no load/clear: Q holds, tc=0.
- Arithmetic: step is zero-extended to bits+1. Sums are computed in bits+1 bits so carry and borrow are never lost.
- step == 0: Q holds, no event, tc=0.
- Up count: nxt = Q + step.
  - nxt <= limit: Q = nxt.
  - Otherwise a boundary event occurs: wrap mode gives Q=0; saturate mode gives Q=limit.
- Down count:
  - step <= Q: Q = Q - step.
  - Otherwise a boundary event occurs: wrap mode gives Q=limit; saturate mode gives Q=0.
- Out of range (Q > limit, e.g. limit lowered at runtime), with an enabled nonzero step:
  - Up: treated as a boundary event per mode.
  - Down: Q=limit, no event.
- limit == 0: Q stays 0. Every enabled nonzero-step count is a boundary event.
- tc: high for exactly the one cycle following each boundary event. It is asserted in the same edge that applies the wrapped or saturated Q. In saturate mode, repeated counts against the bound give tc on every such cycle.
- ovf: set by any boundary event and held until clear or reset. If clear and a boundary event coincide, clear wins.
- Latency: Q, tc and ovf reflect inputs sampled at edge N immediately after edge N (1 cycle). at_max and at_zero are purely combinational from Q and limit.
- Mode and limit inputs may change on any cycle and take effect on the next edge. No internal state is stored beyond Q, tc and ovf.

Test Plan:
- Reset mid-count: bits=8, count up to Q=37, assert reset for 1 cycle with enable=1, load=1 -> Q=0, tc=0, ovf=0 next cycle; load ignored.
- Wrap up: limit=9, step=1, up=1, sat_mode=0, enable continuous from Q=0 -> Q sequence 0..9,0. tc high only the cycle Q returns to 0. ovf=1 afterwards; at_max=1 while Q=9.
- Saturate down with step: limit=200, Q loaded 10, step=4, up=0, sat_mode=1 -> Q 6, 2, 0, 0. tc high on the cycle Q first becomes 0 and on the following held cycle. at_zero=1.
- Load clamp and priority: limit=50, load=1 with D=80, enable=1 -> Q=50, tc=0. Then clear=1 with load=1 -> Q=0, ovf=0.
- Limit lowered below Q: Q=40, set limit=20. Up step 1 in wrap mode -> Q=0, tc=1. Repeat from Q=40 with up=0 -> Q=20, tc=0.
- Edge cases: step=0 with enable=1 -> Q holds, tc=0. With limit=0, up=1, step=3 -> Q=0 and tc=1 every enabled cycle. With bits=8, limit=255, Q=254, step=15, wrap -> Q=0 with no carry loss.

Source files
------------

// File: rtl/udl_mod_counter_if.sv
// Control and status bundle of the up/down/load modulus counter.
// The master drives the controls and observes the count; the counter is the slave.
interface udl_mod_counter_if #(
  parameter int bits      = 8,
  parameter int step_bits = 4
);
  logic                 enable;
  logic                 up;
  logic                 load;
  logic [bits-1:0]      D;
  logic [step_bits-1:0] step;
  logic [bits-1:0]      limit;
  logic                 sat_mode;
  logic                 clear;
  logic [bits-1:0]      Q;
  logic                 tc;
  logic                 ovf;
  logic                 at_max;
  logic                 at_zero;

  modport master (
    output enable, up, load, D, step, limit, sat_mode, clear,
    input  Q, tc, ovf, at_max, at_zero
  );

  modport slave (
    input  enable, up, load, D, step, limit, sat_mode, clear,
    output Q, tc, ovf, at_max, at_zero
  );
endinterface

// File: rtl/udl_mod_counter.sv
// Up/down/load counter over [0, limit] with programmable step, wrap or
// saturate at the bounds, a one-cycle terminal-count pulse and a sticky ovf flag.
module udl_mod_counter #(
  parameter int bits      = 8,
  parameter int step_bits = 4
) (
  input  logic              clk,
  input  logic              reset,
  udl_mod_counter_if.slave  bus
);
  localparam int W1 = bits + 1;

  logic [bits-1:0] q_q, q_d;
  logic            tc_q, tc_d;
  logic            ovf_q, ovf_d;

  logic [W1-1:0]   step_ext;
  logic [W1-1:0]   q_ext;
  logic [W1-1:0]   lim_ext;
  logic [W1-1:0]   sum_ext;
  logic            boundary;

  // Extra bit keeps the carry of q + step so it can be compared against limit.
  assign step_ext = {{(W1-step_bits){1'b0}}, bus.step};
  assign q_ext    = {1'b0, q_q};
  assign lim_ext  = {1'b0, bus.limit};
  assign sum_ext  = q_ext + step_ext;

  always_comb begin
    q_d      = q_q;
    tc_d     = 1'b0;
    ovf_d    = ovf_q;
    boundary = 1'b0;
    if (bus.clear) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (bus.load) begin
      q_d = (bus.D > bus.limit) ? bus.limit : bus.D;
    end else if (bus.enable && (bus.step != '0)) begin
      if (bus.up) begin
        // An out-of-range q always overshoots limit, so it lands here as an event.
        if (sum_ext <= lim_ext) q_d = sum_ext[bits-1:0];
        else                    boundary = 1'b1;
      end else begin
        if (q_q > bus.limit)          q_d = bus.limit;
        else if (step_ext <= q_ext)   q_d = q_q - step_ext[bits-1:0];
        else                          boundary = 1'b1;
      end
      if (boundary) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (bus.up) q_d = bus.sat_mode ? bus.limit : '0;
        else        q_d = bus.sat_mode ? '0 : bus.limit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.Q       = q_q;
  assign bus.tc      = tc_q;
  assign bus.ovf     = ovf_q;
  assign bus.at_max  = (q_q == bus.limit);
  assign bus.at_zero = (q_q == '0);
endmodule

// File: tb/tb_udl_mod_counter.sv
// Directed bench for udl_mod_counter: each scenario task drives vectors and
// compares Q/tc/ovf/at_max/at_zero against hand-computed values.
module tb_udl_mod_counter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  udl_mod_counter_if #(.bits(8), .step_bits(4)) bus ();

  udl_mod_counter #(.bits(8), .step_bits(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.enable   = 1'b0;
    bus.up       = 1'b1;
    bus.load     = 1'b0;
    bus.D        = 8'd0;
    bus.step     = 4'd1;
    bus.sat_mode = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] lim, input logic [7:0] val);
    bus.limit = lim;
    bus.D     = val;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.limit = 8'd9;
    tick();
    tick();
    checks++; if (bus.Q !== 8'd0) begin errors++; $display("FAIL reset_q got %0d expected 0", bus.Q); end
    checks++; if (bus.tc !== 1'b0 || bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_flags got tc=%0b ovf=%0b expected 0 0", bus.tc, bus.ovf); end
    checks++; if (bus.at_zero !== 1'b1 || bus.at_max !== 1'b0) begin errors++; $display("FAIL reset_at got zero=%0b max=%0b expected 1 0", bus.at_zero, bus.at_max); end
    reset = 1'b0;
    do_load(8'd255, 8'd30);
    bus.enable = 1'b1;
    bus.step   = 4'd7;
    tick();
    checks++; if (bus.Q !== 8'd37) begin errors++; $display("FAIL reset_precount got %0d expected 37", bus.Q); end
    reset    = 1'b1;
    bus.load = 1'b1;
    bus.D    = 8'd100;
    tick();
    checks++; if (bus.Q !== 8'd0 || bus.tc !== 1'b0 || bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_mid got q=%0d tc=%0b ovf=%0b expected 0 0 0", bus.Q, bus.tc, bus.ovf); end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_wrap_up();
    do_clear();
    bus.limit    = 8'd9;
    bus.step     = 4'd1;
    bus.up       = 1'b1;
    bus.sat_mode = 1'b0;
    bus.enable   = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++; if (bus.Q !== 8'(i) || bus.tc !== 1'b0) begin errors++; $display("FAIL wrap_seq got q=%0d tc=%0b expected q=%0d tc=0", bus.Q, bus.tc, i); end
      checks++; if (bus.at_max !== (i == 9)) begin errors++; $display("FAIL wrap_at_max got %0b at q=%0d expected %0b", bus.at_max, bus.Q, (i == 9)); end
    end
    tick();
    checks++; if (bus.Q !== 8'd0 || bus.tc !== 1'b1 || bus.ovf !== 1'b1) begin errors++; $display("FAIL wrap_event got q=%0d tc=%0b ovf=%0b expected 0 1 1", bus.Q, bus.tc, bus.ovf); end
    bus.enable = 1'b0;
    tick();
    checks++; if (bus.Q !== 8'd0 || bus.tc !== 1'b0 || bus.ovf !== 1'b1) begin errors++; $display("FAIL wrap_hold got q=%0d tc=%0b ovf=%0b expected 0 0 1", bus.Q, bus.tc, bus.ovf); end
  endtask

  task automatic test_sat_down();
    logic [7:0] exp_q[4];
    logic       exp_tc[4];
    exp_q  = '{8'd6, 8'd2, 8'd0, 8'd0};
    exp_tc = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_clear();
    do_load(8'd200, 8'd10);
    checks++; if (bus.Q !== 8'd10) begin errors++; $display("FAIL sat_load got %0d expected 10", bus.Q); end
    bus.step     = 4'd4;
    bus.up       = 1'b0;
    bus.sat_mode = 1'b1;
    bus.enable   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.Q !== exp_q[i] || bus.tc !== exp_tc[i]) begin errors++; $display("FAIL sat_down step %0d got q=%0d tc=%0b expected q=%0d tc=%0b", i, bus.Q, bus.tc, exp_q[i], exp_tc[i]); end
    end
    checks++; if (bus.at_zero !== 1'b1 || bus.ovf !== 1'b1) begin errors++; $display("FAIL sat_flags got zero=%0b ovf=%0b expected 1 1", bus.at_zero, bus.ovf); end
    idle_inputs();
  endtask

  task automatic test_load_clamp();
    bus.limit  = 8'd50;
    bus.D      = 8'd80;
    bus.load   = 1'b1;
    bus.enable = 1'b1;
    bus.up     = 1'b1;
    tick();
    checks++; if (bus.Q !== 8'd50 || bus.tc !== 1'b0) begin errors++; $display("FAIL load_clamp got q=%0d tc=%0b expected 50 0", bus.Q, bus.tc); end
    checks++; if (bus.ovf !== 1'b1 || bus.at_max !== 1'b1) begin errors++; $display("FAIL load_keeps_ovf got ovf=%0b max=%0b expected 1 1", bus.ovf, bus.at_max); end
    bus.clear = 1'b1;
    tick();
    checks++; if (bus.Q !== 8'd0 || bus.ovf !== 1'b0) begin errors++; $display("FAIL clear_over_load got q=%0d ovf=%0b expected 0 0", bus.Q, bus.ovf); end
    idle_inputs();
  endtask

  task automatic test_limit_lowered();
    do_load(8'd255, 8'd40);
    bus.limit    = 8'd20;
    bus.up       = 1'b1;
    bus.step     = 4'd1;
    bus.sat_mode = 1'b0;
    bus.enable   = 1'b1;
    tick();
    checks++; if (bus.Q !== 8'd0 || bus.tc !== 1'b1) begin errors++; $display("FAIL lowered_up got q=%0d tc=%0b expected 0 1", bus.Q, bus.tc); end
    bus.enable = 1'b0;
    do_clear();
    do_load(8'd255, 8'd40);
    bus.limit  = 8'd20;
    bus.up     = 1'b0;
    bus.enable = 1'b1;
    tick();
    checks++; if (bus.Q !== 8'd20 || bus.tc !== 1'b0 || bus.ovf !== 1'b0) begin errors++; $display("FAIL lowered_down got q=%0d tc=%0b ovf=%0b expected 20 0 0", bus.Q, bus.tc, bus.ovf); end
    idle_inputs();
  endtask

  task automatic test_edges();
    bus.limit  = 8'd20;
    bus.step   = 4'd0;
    bus.enable = 1'b1;
    tick();
    checks++; if (bus.Q !== 8'd20 || bus.tc !== 1'b0) begin errors++; $display("FAIL step_zero got q=%0d tc=%0b expected 20 0", bus.Q, bus.tc); end
    bus.limit = 8'd0;
    bus.up    = 1'b1;
    bus.step  = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.Q !== 8'd0 || bus.tc !== 1'b1) begin errors++; $display("FAIL limit_zero cycle %0d got q=%0d tc=%0b expected 0 1", i, bus.Q, bus.tc); end
    end
    bus.enable = 1'b0;
    do_load(8'd255, 8'd254);
    bus.step     = 4'd15;
    bus.sat_mode = 1'b0;
    bus.enable   = 1'b1;
    tick();
    checks++; if (bus.Q !== 8'd0 || bus.tc !== 1'b1) begin errors++; $display("FAIL carry_wrap got q=%0d tc=%0b expected 0 1", bus.Q, bus.tc); end
    bus.enable = 1'b0;
    do_load(8'd255, 8'd254);
    bus.sat_mode = 1'b1;
    bus.enable   = 1'b1;
    tick();
    checks++; if (bus.Q !== 8'd255 || bus.tc !== 1'b1 || bus.at_max !== 1'b1) begin errors++; $display("FAIL carry_sat got q=%0d tc=%0b max=%0b expected 255 1 1", bus.Q, bus.tc, bus.at_max); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_clear();
    do_load(8'd12, 8'd2);
    bus.up       = 1'b0;
    bus.step     = 4'd5;
    bus.sat_mode = 1'b0;
    bus.enable   = 1'b1;
    tick();
    checks++; if (bus.Q !== 8'd12 || bus.tc !== 1'b1) begin errors++; $display("FAIL down_wrap got q=%0d tc=%0b expected 12 1", bus.Q, bus.tc); end
    tick();
    checks++; if (bus.Q !== 8'd7 || bus.tc !== 1'b0 || bus.ovf !== 1'b1) begin errors++; $display("FAIL down_after_wrap got q=%0d tc=%0b ovf=%0b expected 7 0 1", bus.Q, bus.tc, bus.ovf); end
    bus.up    = 1'b1;
    bus.clear = 1'b1;
    bus.step  = 4'd9;
    tick();
    checks++; if (bus.Q !== 8'd0 || bus.ovf !== 1'b0 || bus.tc !== 1'b0) begin errors++; $display("FAIL clear_over_event got q=%0d ovf=%0b tc=%0b expected 0 0 0", bus.Q, bus.ovf, bus.tc); end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load_clamp();
    test_limit_lowered();
    test_edges();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
